// File: rtl/dsp48a1_cmd_sequencer.sv
// Command sequencer for a DSP48A1 slice: accepts one command, steps the slice pipeline, returns P.
// Optional macro DSP_SEQ_CARRY_EN routes CMD_CIN into OPMODE[5] and returns the slice CARRYOUT.
module dsp48a1_cmd_sequencer #(
    parameter int SIZE1   = 18,
    parameter int SIZE3   = 48,
    parameter int P_STAGE = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [SIZE1-1:0] CMD_A,
    input  logic [SIZE1-1:0] CMD_B,
    input  logic [SIZE1-1:0] CMD_D,
    input  logic [SIZE3-1:0] CMD_C,
    input  logic             CMD_CIN,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [SIZE3-1:0] RSP_P,
    output logic             RSP_CARRY,
    output logic             RSP_ERR,
    output logic [SIZE1-1:0] DSP_A,
    output logic [SIZE1-1:0] DSP_B,
    output logic [SIZE1-1:0] DSP_D,
    output logic [SIZE3-1:0] DSP_C,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    output logic             DSP_CEP,
    output logic             DSP_RST,
    input  logic [SIZE3-1:0] DSP_P,
    input  logic             DSP_CARRYOUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAPT,
        S_RESP
    } state_t;

    localparam logic [2:0] LP_P_STAGE = 3'(P_STAGE);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [SIZE3-1:0] r_rsp_p;
    logic             r_rsp_carry;
    logic             r_rsp_err;
    logic [SIZE1-1:0] r_dsp_a;
    logic [SIZE1-1:0] r_dsp_b;
    logic [SIZE1-1:0] r_dsp_d;
    logic [SIZE3-1:0] r_dsp_c;
    logic [7:0]       r_dsp_opmode;
    logic             r_dsp_ce;
    logic             r_dsp_cep;

    logic [7:0]       w_opmode;
    logic             w_op_valid;

    // OPMODE bits: [1:0] X mux, [3:2] Z mux, [4] pre-adder, [5] carry-in, [6] pre-sub, [7] post-sub
    always_comb begin
        w_opmode   = 8'h00;
        w_op_valid = 1'b1;
        case (CMD_OP)
            3'd0:    w_opmode = 8'h01;
            3'd1:    w_opmode = 8'h09;
            3'd2:    w_opmode = 8'h0D;
            3'd3:    w_opmode = 8'h11;
            3'd4:    w_opmode = 8'h51;
            3'd5:    w_opmode = 8'h8D;
            3'd6:    w_opmode = 8'h00;
            default: w_op_valid = 1'b0;
        endcase
`ifdef DSP_SEQ_CARRY_EN
        w_opmode[5] = CMD_CIN;
`endif
    end

`ifndef DSP_SEQ_CARRY_EN
    logic w_unused_carry;
    assign w_unused_carry = CMD_CIN ^ DSP_CARRYOUT;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_p      <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_dsp_a      <= '0;
            r_dsp_b      <= '0;
            r_dsp_d      <= '0;
            r_dsp_c      <= '0;
            r_dsp_opmode <= 8'h00;
            r_dsp_ce     <= 1'b0;
            r_dsp_cep    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_dsp_ce    <= 1'b0;
                    r_dsp_cep   <= 1'b0;
                    if (r_cmd_ready && CMD_VALID) begin
                        r_cmd_ready  <= 1'b0;
                        r_dsp_a      <= CMD_A;
                        r_dsp_b      <= CMD_B;
                        r_dsp_d      <= CMD_D;
                        r_dsp_c      <= CMD_C;
                        r_dsp_opmode <= w_opmode;
                        if (w_op_valid) begin
                            r_state  <= S_RUN;
                            r_cnt    <= 3'd0;
                            r_dsp_ce <= 1'b1;
                        end else begin
                            // Reserved opcode is answered immediately without clocking the slice
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_p     <= '0;
                            r_rsp_carry <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt     <= r_cnt + 3'd1;
                    r_dsp_cep <= ((r_cnt + 3'd1) == LP_P_STAGE);
                    if (r_cnt == LP_P_STAGE) begin
                        r_state   <= S_CAPT;
                        r_dsp_ce  <= 1'b0;
                        r_dsp_cep <= 1'b0;
                    end
                end
                S_CAPT: begin
                    r_rsp_p     <= DSP_P;
`ifdef DSP_SEQ_CARRY_EN
                    r_rsp_carry <= DSP_CARRYOUT;
`else
                    r_rsp_carry <= 1'b0;
`endif
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_p     <= '0;
                        r_rsp_carry <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY  = r_cmd_ready;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_P      = r_rsp_p;
    assign RSP_CARRY  = r_rsp_carry;
    assign RSP_ERR    = r_rsp_err;
    assign DSP_A      = r_dsp_a;
    assign DSP_B      = r_dsp_b;
    assign DSP_D      = r_dsp_d;
    assign DSP_C      = r_dsp_c;
    assign DSP_OPMODE = r_dsp_opmode;
    assign DSP_CE     = r_dsp_ce;
    assign DSP_CEP    = r_dsp_cep;
    assign DSP_RST    = RST;

endmodule

// File: tb/tb_dsp48a1_cmd_sequencer.sv
// Scoreboard bench for dsp48a1_cmd_sequencer with a small behavioural DSP48A1 slice attached.
module tb_dsp48a1_cmd_sequencer;

   localparam int SIZE1   = 18;
   localparam int SIZE3   = 48;
   localparam int P_STAGE = 2;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             CMD_VALID = 1'b0;
   logic             CMD_READY;
   logic [2:0]       CMD_OP = '0;
   logic [SIZE1-1:0] CMD_A = '0, CMD_B = '0, CMD_D = '0;
   logic [SIZE3-1:0] CMD_C = '0;
   logic             CMD_CIN = 1'b0;
   logic             RSP_VALID;
   logic             RSP_READY = 1'b1;
   logic [SIZE3-1:0] RSP_P;
   logic             RSP_CARRY, RSP_ERR;
   logic [SIZE1-1:0] DSP_A, DSP_B, DSP_D;
   logic [SIZE3-1:0] DSP_C;
   logic [7:0]       DSP_OPMODE;
   logic             DSP_CE, DSP_CEP, DSP_RST;
   logic [SIZE3-1:0] DSP_P;
   logic             DSP_CARRYOUT;

   typedef struct packed {
      logic [47:0] p;
      logic        carry;
      logic        err;
   } rsp_t;

   rsp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

`ifdef DSP_SEQ_CARRY_EN
   localparam logic EXP_WRAP_CARRY = 1'b1;
`else
   localparam logic EXP_WRAP_CARRY = 1'b0;
`endif

   dsp48a1_cmd_sequencer #(.SIZE1(SIZE1), .SIZE3(SIZE3), .P_STAGE(P_STAGE)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_D(CMD_D), .CMD_C(CMD_C), .CMD_CIN(CMD_CIN),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_P(RSP_P),
      .RSP_CARRY(RSP_CARRY), .RSP_ERR(RSP_ERR),
      .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_C(DSP_C),
      .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE), .DSP_CEP(DSP_CEP), .DSP_RST(DSP_RST),
      .DSP_P(DSP_P), .DSP_CARRYOUT(DSP_CARRYOUT)
   );

   always #5 CLK = ~CLK;

   // Simplified slice: pre-adder folded into the first register stage, then M, then P/CARRYOUT
   logic signed [17:0] mA, mB1;
   logic signed [35:0] mM;
   logic [47:0]        mC, mP;
   logic [4:0]         mOpPost;
   logic               mCin, mCout;
   logic [47:0]        muxX, muxZ;
   logic [48:0]        postSum;

   always_comb begin
      muxX = '0;
      muxZ = '0;
      case (mOpPost[1:0])
         2'd1:    muxX = {{12{mM[35]}}, mM};
         2'd2:    muxX = mP;
         default: muxX = '0;
      endcase
      case (mOpPost[3:2])
         2'd2:    muxZ = mP;
         2'd3:    muxZ = mC;
         default: muxZ = '0;
      endcase
      if (mOpPost[4])
         postSum = {1'b0, muxZ} - ({1'b0, muxX} + {48'd0, mCin});
      else
         postSum = {1'b0, muxZ} + {1'b0, muxX} + {48'd0, mCin};
   end

   always @(posedge CLK) begin
      if (DSP_RST) begin
         mA <= '0; mB1 <= '0; mM <= '0; mC <= '0; mP <= '0;
         mOpPost <= '0; mCin <= 1'b0; mCout <= 1'b0;
      end else begin
         if (DSP_CE) begin
            mA      <= DSP_A;
            mB1     <= DSP_OPMODE[4] ? (DSP_OPMODE[6] ? DSP_D - DSP_B : DSP_D + DSP_B) : DSP_B;
            mC      <= DSP_C;
            mOpPost <= {DSP_OPMODE[7], DSP_OPMODE[3:0]};
            mCin    <= DSP_OPMODE[5];
            mM      <= mA * mB1;
         end
         if (DSP_CEP) begin
            mP    <= postSum[47:0];
            mCout <= postSum[48];
         end
      end
   end

   assign DSP_P        = mP;
   assign DSP_CARRYOUT = mCout;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Monitor pops the oldest expected response on every response handshake
   always @(negedge CLK) begin : monitor
      rsp_t e;
      if (!RST && RSP_VALID && RSP_READY) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_rsp: actual=%0h required=none", RSP_P);
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp_p", RSP_P, e.p);
            checkOutput("rsp_carry", RSP_CARRY, e.carry);
            checkOutput("rsp_err", RSP_ERR, e.err);
         end
      end
   end

   task automatic waitReady(input string name);
      int w = 0;
      while (!CMD_READY && w < 20) begin
         tick();
         w++;
      end
      checkOutput({name, "_cmd_ready"}, CMD_READY, 1);
   endtask

   task automatic applyStimulus(input string name, input logic [2:0] op,
                                input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                                input logic [47:0] c, input logic [47:0] expP,
                                input logic expCarry, input logic expErr, input bit stall);
      int n, ceHits, cepHits, cepAt, expLat;
      waitReady(name);
      CMD_VALID = 1'b1; CMD_OP = op; CMD_A = a; CMD_B = b; CMD_D = d; CMD_C = c; CMD_CIN = 1'b0;
      RSP_READY = !stall;
      expQ.push_back({expP, expCarry, expErr});
      tick();
      CMD_VALID = 1'b0;
      n = 1; ceHits = 0; cepHits = 0; cepAt = 0;
      while (!RSP_VALID && n < 20) begin
         if (DSP_CE) ceHits++;
         if (DSP_CEP) begin
            cepHits++;
            cepAt = n;
         end
         tick();
         n++;
      end
      expLat = expErr ? 1 : P_STAGE + 3;
      checkOutput({name, "_latency"}, n, expLat);
      checkOutput({name, "_ce_cycles"}, ceHits, expErr ? 0 : P_STAGE + 1);
      checkOutput({name, "_cep_cycles"}, cepHits, expErr ? 0 : 1);
      checkOutput({name, "_cep_at"}, cepAt, expErr ? 0 : P_STAGE + 1);
      if (stall) begin
         for (int i = 0; i < 3; i++) begin
            CMD_VALID = 1'b1;
            CMD_OP = 3'd0;
            checkOutput({name, "_stall_valid"}, RSP_VALID, 1);
            checkOutput({name, "_stall_p"}, RSP_P, expP);
            checkOutput({name, "_stall_cmd_ready"}, CMD_READY, 0);
            tick();
         end
         CMD_VALID = 1'b0;
         RSP_READY = 1'b1;
         tick();
         checkOutput({name, "_ready_after_hs"}, CMD_READY, 1);
      end else begin
         tick();
      end
      checkOutput({name, "_valid_cleared"}, RSP_VALID, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit seenValid;
      repeat (3) tick();
      checkOutput("reset_cmd_ready", CMD_READY, 0);
      checkOutput("reset_rsp_valid", RSP_VALID, 0);
      checkOutput("reset_dsp_ce", DSP_CE, 0);
      checkOutput("reset_dsp_cep", DSP_CEP, 0);
      checkOutput("reset_opmode", DSP_OPMODE, 0);
      checkOutput("reset_dsp_rst", DSP_RST, 1);
      RST = 1'b0;
      tick();
      checkOutput("post_reset_cmd_ready", CMD_READY, 1);
      checkOutput("post_reset_dsp_rst", DSP_RST, 0);

      applyStimulus("mul",       3'd0, 18'd3, 18'd5, 18'd0,  48'd0,   48'd15,  1'b0, 1'b0, 1'b0);
      applyStimulus("mac",       3'd1, 18'd2, 18'd4, 18'd0,  48'd0,   48'd23,  1'b0, 1'b0, 1'b0);
      applyStimulus("clr",       3'd6, 18'd9, 18'd9, 18'd0,  48'd0,   48'd0,   1'b0, 1'b0, 1'b0);
      applyStimulus("premul",    3'd3, 18'd3, 18'd4, 18'd10, 48'd0,   48'd42,  1'b0, 1'b0, 1'b0);
      applyStimulus("presubmul", 3'd4, 18'd3, 18'd4, 18'd10, 48'd0,   48'd18,  1'b0, 1'b0, 1'b0);
      applyStimulus("muladdc",   3'd2, 18'd7, 18'd6, 18'd0,  48'd100, 48'd142, 1'b0, 1'b0, 1'b0);
      applyStimulus("msubc",     3'd5, 18'd4, 18'd5, 18'd0,  48'd50,  48'd30,  1'b0, 1'b0, 1'b1);
      applyStimulus("reserved",  3'd7, 18'd1, 18'd1, 18'd1,  48'd1,   48'd0,   1'b0, 1'b1, 1'b0);

      // Reset while the command is in RUN with cnt==1
      waitReady("abort");
      CMD_VALID = 1'b1; CMD_OP = 3'd0; CMD_A = 18'd9; CMD_B = 18'd9;
      tick();
      CMD_VALID = 1'b0;
      tick();
      RST = 1'b1;
      #1;
      checkOutput("abort_dsp_rst", DSP_RST, 1);
      tick();
      RST = 1'b0;
      checkOutput("abort_dsp_ce", DSP_CE, 0);
      checkOutput("abort_dsp_cep", DSP_CEP, 0);
      checkOutput("abort_dsp_a", DSP_A, 0);
      checkOutput("abort_opmode", DSP_OPMODE, 0);
      checkOutput("abort_rsp_valid", RSP_VALID, 0);
      seenValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (RSP_VALID) seenValid = 1'b1;
         tick();
      end
      checkOutput("abort_no_rsp", seenValid, 0);

      applyStimulus("mac_after_rst", 3'd1, 18'd1, 18'd1, 18'd0, 48'd0, 48'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus("carry_wrap", 3'd2, 18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0,
                    EXP_WRAP_CARRY, 1'b0, 1'b0);

      repeat (2) tick();
      checkOutput("queue_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsp48a1_cmd_sequencer.md
Name: dsp48a1_cmd_sequencer

Overview:
- Command-side initiator for the spartan6_DSP (DSP48A1) slice. It accepts one arithmetic command at a time over a valid/ready handshake and drives the slice's operand, OPMODE and clock-enable inputs.
- It tracks the slice pipeline, captures P/CARRYOUT at the correct cycle, and returns the result over a valid/ready response channel.
- Targets the slice configuration A0REG=0, A1REG=1, B0REG=0, B1REG=1, CREG=1, DREG=1, OPMODEREG=1, CARRYINREG=1, MREG=1, PREG=1, CARRYOUTREG=1, CARRYINSEL="OPMODE5".

Parameters:
- SIZE1, 18, A/B/D operand width
- SIZE3, 48, C and P width
- P_STAGE, 2, cycle index (0-based from first drive cycle) in which DSP_CEP is pulsed; legal range 1..7

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept a command
- CMD_OP  in  3  opcode
- CMD_A, CMD_B, CMD_D  in  SIZE1  operands
- CMD_C  in  SIZE3  operand
- CMD_CIN  in  1  carry-in (used only with DSP_SEQ_CARRY_EN)
- RSP_VALID  out  1  result present
- RSP_READY  in  1  consumer takes result
- RSP_P  out  SIZE3  result
- RSP_CARRY  out  1  carry-out of the result
- RSP_ERR  out  1  reserved opcode was received
- DSP_A, DSP_B, DSP_D  out  SIZE1  to slice A/B/D
- DSP_C  out  SIZE3  to slice C
- DSP_OPMODE  out  8  to slice OPMODE
- DSP_CE  out  1  to slice CEA/CEB/CEC/CED/CEM/CEOPMODE/CECARRYIN
- DSP_CEP  out  1  to slice CEP (P and CARRYOUT registers)
- DSP_RST  out  1  to all slice RST* inputs; combinational copy of RST
- DSP_P  in  SIZE3  from slice P
- DSP_CARRYOUT  in  1  from slice CARRYOUT

Behaviour:
- Reset: state=IDLE, counter=0, all registered outputs 0 (DSP_A..DSP_OPMODE, DSP_CE, DSP_CEP, RSP_*). CMD_READY=1 in the cycle after RST deasserts.
- States: IDLE, RUN, CAPT, RESP.
- IDLE:
  - CMD_READY=1; all other outputs 0 except held DSP_* operands.
  - On CMD_VALID in this cycle: register operands into DSP_A/B/C/D and decode the opcode into DSP_OPMODE.
  - Valid opcode -> RUN with cnt=0. Reserved opcode -> RESP directly with RSP_ERR=1 and RSP_P=0; the slice is not touched.
- Opcode to OPMODE mapping:
  - 0 MUL, P=A*B: 0x01
  - 1 MAC, P=P+A*B: 0x09
  - 2 MULADDC, P=C+A*B: 0x0D
  - 3 PREMUL, P=(D+B)*A: 0x11
  - 4 PRESUBMUL, P=(D-B)*A: 0x51
  - 5 MSUBC, P=C-A*B: 0x8D
  - 6 CLR, P=0: 0x00
  - 7 reserved
- RUN:
  - DSP_CE=1 every cycle and DSP_* are held constant.
  - DSP_CEP=1 only when cnt==P_STAGE, so MAC accumulates exactly once.
  - cnt increments each cycle; after the cnt==P_STAGE cycle -> CAPT.
- CAPT (1 cycle): DSP_CE=0, DSP_CEP=0. Register DSP_P into RSP_P and DSP_CARRYOUT into RSP_CARRY, then -> RESP.
- RESP:
  - RSP_VALID=1; RSP_P/RSP_CARRY/RSP_ERR held stable until RSP_READY=1.
  - On handshake -> IDLE; RSP_VALID and RSP_ERR clear next cycle.
- Latency, default P_STAGE=2: command accepted at edge ending cycle k -> RUN in cycles k+1..k+3, CAPT in k+4, RSP_VALID=1 from k+5. Generally RSP_VALID rises at k+P_STAGE+3.
- Throughput: one command in flight. CMD_READY=0 from accept until the response handshake completes, so the next accept is at the earliest 1 cycle after the handshake.
- RSP_READY held high before RSP_VALID has no effect.
- RST in any state (including mid-RUN) returns to IDLE at that edge and drops any response. DSP_RST=1 during RST, so slice P is also cleared.
- Arithmetic is performed entirely by the slice; the sequencer does no width extension and passes operands unmodified.

Optional Feature:
- Macro DSP_SEQ_CARRY_EN.
- Defined: DSP_OPMODE[5] = CMD_CIN registered at accept; RSP_CARRY = captured DSP_CARRYOUT.
- Undefined: OPMODE[5] forced 0, CMD_CIN ignored, RSP_CARRY tied 0.
- Port list is identical in both builds.

Test Plan:
- Reset, then MUL A=3 B=5 accepted at cycle k -> RSP_VALID at k+5, RSP_P=15, RSP_ERR=0; DSP_CEP high exactly 1 cycle (k+3).
- Then MAC A=2 B=4 -> RSP_P=23; then CLR -> 0; then PREMUL D=10 B=4 A=3 -> 42; PRESUBMUL same operands -> 18.
- MULADDC C=100 A=7 B=6 -> 142; MSUBC C=50 A=4 B=5 -> 30.
- RSP_READY held low 3 cycles after RSP_VALID -> RSP_P stable, CMD_READY=0, new CMD_VALID ignored; RSP_READY=1 -> CMD_READY=1 next cycle.
- CMD_OP=7 -> RSP_VALID at k+1 with RSP_ERR=1, RSP_P=0, DSP_CE/DSP_CEP never asserted.
- RST pulsed during RUN cnt=1 -> next cycle IDLE, all outputs 0, no RSP_VALID.
- With DSP_SEQ_CARRY_EN: MULADDC C=48'hFFFFFFFFFFFF A=1 B=1 -> RSP_P=0, RSP_CARRY=1. Without the macro: RSP_CARRY=0.
